// File: rtl/t03_tick_timer_if.sv
// Control/status bundle between the tick timer and its software-facing controller.
// The master drives the requests; the timer (slave) returns its count and status flags.
interface t03_tick_timer_if #(
  parameter int CNT_W = 16
);
  logic             tick;
  logic             start;
  logic             stop;
  logic             ack;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             done;
  logic             tick_fault;

  modport master (
    output tick, start, stop, ack, load_val,
    input  remaining, busy, done, tick_fault
  );

  modport slave (
    input  tick, start, stop, ack, load_val,
    output remaining, busy, done, tick_fault
  );
endinterface

// File: rtl/t03_tick_timer.sv
// Countdown timer consuming divider ticks, with a missing-tick watchdog.
// Define T03_TICK_TIMER_RELOAD_EN for periodic (auto-reload) mode.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | counting received ticks down; watchdog armed
// DONE   | expired, done held until ack (or stop)
module t03_tick_timer #(
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 24,
  parameter int GAP_MAX = 10000002
) (
  input  logic            hwclk,
  input  logic            nrst,
  t03_tick_timer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, done_q, done_d, fault_q, fault_d;
  logic             accept;
`ifdef T03_TICK_TIMER_RELOAD_EN
  logic [CNT_W-1:0] period_q, period_d;
`endif

  always_comb begin
    state_d = state;
    rem_d   = rem_q;
    gap_d   = gap_q;
    done_d  = done_q;
    fault_d = fault_q;
    accept  = 1'b0;
`ifdef T03_TICK_TIMER_RELOAD_EN
    period_d = period_q;
`endif
    case (state)
      S_IDLE: accept = bus.start;
      S_RUN: begin
`ifdef T03_TICK_TIMER_RELOAD_EN
        done_d = 1'b0;
`endif
        if (bus.stop) begin
          state_d = S_IDLE;
          rem_d   = '0;
          gap_d   = '0;
        end else if (bus.tick) begin
          gap_d = '0;
          if (rem_q > CNT_ONE) begin
            rem_d = rem_q - CNT_ONE;
          end else begin
            done_d = 1'b1;
`ifdef T03_TICK_TIMER_RELOAD_EN
            rem_d  = period_q;
`else
            rem_d   = '0;
            state_d = S_DONE;
`endif
          end
        end else if (gap_q == GAP_LAST) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
          rem_d   = '0;
          gap_d   = '0;
        end else if (gap_q != '1) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        // stop doubles as ack here, so stop+start also restarts
        if (bus.ack || bus.stop) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
          accept  = bus.start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      rem_d   = bus.load_val;
      fault_d = 1'b0;
      gap_d   = '0;
`ifdef T03_TICK_TIMER_RELOAD_EN
      period_d = bus.load_val;
`endif
      if (bus.load_val == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

`ifdef T03_TICK_TIMER_RELOAD_EN
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) period_q <= '0;
    else       period_q <= period_d;
  end
`endif

  assign bus.remaining  = rem_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.tick_fault = fault_q;

endmodule

// File: tb/tb_t03_tick_timer.sv
// Scoreboard bench for t03_tick_timer: directed scenarios then random traffic,
// expected outputs from a behavioural model queued per cycle and checked by a monitor.
module tb_t03_tick_timer;
  localparam int CNT_W   = 16;
  localparam int GAP_W   = 24;
  localparam int GAP_MAX = 20;

  logic hwclk = 1'b0;
  logic nrst  = 1'b0;
  always #5 hwclk = ~hwclk;

  t03_tick_timer_if #(.CNT_W(CNT_W)) bus ();

  t03_tick_timer #(.CNT_W(CNT_W), .GAP_W(GAP_W), .GAP_MAX(GAP_MAX)) dut (
    .hwclk (hwclk),
    .nrst  (nrst),
    .bus   (bus)
  );

  typedef struct {
    int rem;
    bit busy;
    bit done;
    bit fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // behavioural model: phase 0 waiting, 1 counting, 2 expired
  int m_phase, m_left, m_since, m_period;
  bit m_done, m_fault;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_since = 0; m_period = 0; m_done = 0; m_fault = 0;
  endtask

  task automatic model_accept(input int lv);
    m_left = lv; m_period = lv; m_fault = 0; m_since = 0;
    if (lv == 0) begin m_phase = 2; m_done = 1; end
    else m_phase = 1;
  endtask

  task automatic model_step(input bit tk, input bit st, input bit sp, input bit ak, input int lv);
    if (m_phase == 0) begin
      if (st) model_accept(lv);
    end else if (m_phase == 1) begin
`ifdef T03_TICK_TIMER_RELOAD_EN
      m_done = 0;
`endif
      if (sp) begin
        m_phase = 0; m_left = 0; m_since = 0;
      end else if (tk) begin
        m_since = 0;
        m_left  = m_left - 1;
        if (m_left == 0) begin
          m_done = 1;
`ifdef T03_TICK_TIMER_RELOAD_EN
          m_left = m_period;
`else
          m_phase = 2;
`endif
        end
      end else begin
        m_since = m_since + 1;
        if (m_since == GAP_MAX) begin
          m_fault = 1; m_phase = 0; m_left = 0; m_since = 0;
        end
      end
    end else begin
      if (ak || sp) begin
        m_done = 0; m_phase = 0;
        if (st) model_accept(lv);
      end
    end
  endtask

  task automatic cyc(input bit tk, input bit st, input bit sp, input bit ak, input int lv);
    exp_t e;
    @(negedge hwclk);
    bus.tick = tk; bus.start = st; bus.stop = sp; bus.ack = ak;
    bus.load_val = CNT_W'(lv);
    model_step(tk, st, sp, ak, lv);
    e.rem = m_left; e.busy = (m_phase == 1); e.done = m_done; e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic reset_mid();
    @(posedge hwclk);
    #2;
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.ack = 0; bus.load_val = '0;
    nrst = 1'b0;
    #1;
    chk("rst_remaining", int'(bus.remaining), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_fault", int'(bus.tick_fault), 0);
    model_reset();
    @(negedge hwclk);
    nrst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge hwclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("remaining", int'(bus.remaining), e.rem);
        chk("busy", int'(bus.busy), int'(e.busy));
        chk("done", int'(bus.done), int'(e.done));
        chk("tick_fault", int'(bus.tick_fault), int'(e.fault));
      end
    end
  end

  initial begin : stim
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.ack = 0; bus.load_val = '0;
    model_reset();
    #3;
    chk("por_remaining", int'(bus.remaining), 0);
    chk("por_busy", int'(bus.busy), 0);
    chk("por_done", int'(bus.done), 0);
    chk("por_fault", int'(bus.tick_fault), 0);
    @(negedge hwclk);
    nrst = 1'b1;

    // reset mid-count with 7 remaining
    cyc(0, 1, 0, 0, 7);
    idle(3);
    reset_mid();
    idle(2);

    // one-shot of 3 ticks spaced 5 cycles
    cyc(0, 1, 0, 0, 3);
    for (int k = 0; k < 3; k++) begin
      idle(4);
      cyc(1, 0, 0, 0, 0);
    end
    idle(4);
    cyc(0, 1, 0, 0, 5);   // start without ack is ignored
    cyc(0, 0, 0, 1, 0);
    idle(2);

    // zero load, then ack+start back-to-back
    cyc(0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 1, 2);
    idle(2);
    cyc(0, 0, 1, 0, 0);

    // stop beats tick
    cyc(0, 1, 0, 0, 5);
    idle(2);
    cyc(1, 0, 1, 0, 0);
    idle(3);

    // watchdog expiry, then a clean run with ticks every 10 cycles
    cyc(0, 1, 0, 0, 4);
    idle(25);
    cyc(0, 1, 0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      idle(9);
      cyc(1, 0, 0, 0, 0);
    end
    idle(3);
    cyc(0, 0, 0, 1, 0);

`ifdef T03_TICK_TIMER_RELOAD_EN
    cyc(0, 1, 0, 0, 2);
    for (int k = 0; k < 6; k++) begin
      idle(3);
      cyc(1, 0, 0, 0, 0);
    end
    idle(3);
    cyc(0, 0, 1, 0, 0);
`endif

    for (int seg = 0; seg < 60; seg++) begin
      int rate;
      bit silent;
      rate   = $urandom_range(1, 12);
      silent = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 50; i++) begin
        bit tk, st, sp, ak;
        tk = !silent && ($urandom_range(1, rate) == 1);
        st = ($urandom_range(0, 15) == 0);
        sp = ($urandom_range(0, 40) == 0);
        ak = ($urandom_range(0, 6) == 0);
        cyc(tk, st, sp, ak, int'($urandom_range(0, 6)));
      end
      if ($urandom_range(0, 9) == 0) reset_mid();
    end

    idle(1);
    repeat (3) @(posedge hwclk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
